// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: resolves branches/jumps from ALU flags, issues a one-cycle
// PC redirect and squashes wrong-path instructions. Optional macro: EXMEM_MISALIGN_EN.
module ex_mem_reg #(
    parameter int KILL_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    input  logic [31:0] alu_result_i,
    input  logic        aN_i,
    input  logic        aZ_i,
    input  logic        aC_i,
    input  logic        aV_i,
    input  logic        is_branch_i,
    input  logic        is_jump_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pc_target_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [1:0]  wb_sel_i,
    output logic        mem_valid_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] mem_wdata_o,
    output logic [4:0]  rd_o,
    output logic [1:0]  wb_sel_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        misalign_o
);

    localparam logic [1:0] KILL_INIT = KILL_SLOTS[1:0];

    logic [1:0]  r_kill_cnt;
    logic        r_mem_valid;
    logic [31:0] r_alu_result;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_mem_wdata;
    logic [4:0]  r_rd;
    logic [1:0]  r_wb_sel;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic w_cond;
    logic w_take;
    logic w_live;
    logic w_mis;
    logic w_fire;

    // Branch condition decode from the ALU flags of a - b
    always_comb begin
        w_cond = 1'b0;
        case (funct3_i)
            3'b000:  w_cond = aZ_i;
            3'b001:  w_cond = ~aZ_i;
            3'b100:  w_cond = aN_i ^ aV_i;
            3'b101:  w_cond = ~(aN_i ^ aV_i);
            3'b110:  w_cond = ~aC_i;
            3'b111:  w_cond = aC_i;
            default: w_cond = 1'b0;
        endcase
    end

    // Liveness, take decision and redirect qualification
    always_comb begin
        w_take = is_jump_i | (is_branch_i & w_cond);
        w_live = ex_valid_i & ~flush_i & (r_kill_cnt == 2'd0);
`ifdef EXMEM_MISALIGN_EN
        w_mis  = w_live & w_take & (pc_target_i[1:0] != 2'b00);
`else
        w_mis  = 1'b0;
`endif
        w_fire = w_live & w_take & ~w_mis;
    end

    // Kill counter: armed by a redirect, consumed by each real younger instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kill_cnt <= 2'd0;
        end else if (!stall_i) begin
            if (w_fire) begin
                r_kill_cnt <= KILL_INIT;
            end else if (ex_valid_i && (r_kill_cnt != 2'd0)) begin
                r_kill_cnt <= r_kill_cnt - 2'd1;
            end
        end
    end

    // Stage register; pulses are dropped while stalled so each redirect fires once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_valid   <= 1'b0;
            r_alu_result  <= 32'd0;
            r_pc_plus4    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_rd          <= 5'd0;
            r_wb_sel      <= 2'd0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else if (stall_i) begin
            r_redirect    <= 1'b0;
        end else begin
            r_mem_valid   <= w_live;
            r_alu_result  <= alu_result_i;
            r_pc_plus4    <= pc_plus4_i;
            r_mem_wdata   <= mem_wdata_i;
            r_rd          <= rd_i;
            r_wb_sel      <= wb_sel_i;
            r_reg_write   <= reg_write_i & w_live;
            r_mem_read    <= mem_read_i & w_live;
            r_mem_write   <= mem_write_i & w_live;
            r_redirect    <= w_fire;
            r_redirect_pc <= pc_target_i;
        end
    end

`ifdef EXMEM_MISALIGN_EN
    logic r_misalign;

    // Misaligned-target pulse, same one-shot behaviour as the redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (stall_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_mis;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign mem_valid_o   = r_mem_valid;
    assign alu_result_o  = r_alu_result;
    assign pc_plus4_o    = r_pc_plus4;
    assign mem_wdata_o   = r_mem_wdata;
    assign rd_o          = r_rd;
    assign wb_sel_o      = r_wb_sel;
    assign reg_write_o   = r_reg_write;
    assign mem_read_o    = r_mem_read;
    assign mem_write_o   = r_mem_write;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the stage.
module tb_ex_mem_reg;

    localparam int KS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0, ex_valid_i = 1'b0;
    logic [31:0] alu_result_i = 32'd0, pc_target_i = 32'd0, pc_plus4_i = 32'd0, mem_wdata_i = 32'd0;
    logic        aN_i = 1'b0, aZ_i = 1'b0, aC_i = 1'b0, aV_i = 1'b0;
    logic        is_branch_i = 1'b0, is_jump_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        reg_write_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [1:0]  wb_sel_i = 2'd0;

    logic        mem_valid_o, reg_write_o, mem_read_o, mem_write_o, redirect_o, misalign_o;
    logic [31:0] alu_result_o, pc_plus4_o, mem_wdata_o, redirect_pc_o;
    logic [4:0]  rd_o;
    logic [1:0]  wb_sel_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the MEM side must show, and how many younger instructions remain to squash
    logic        e_valid, e_rw, e_mr, e_mw, e_redir, e_mis;
    logic [31:0] e_alu, e_pc4, e_wdata, e_rpc;
    logic [4:0]  e_rd;
    logic [1:0]  e_wb;
    int          m_squash;

    ex_mem_reg #(.KILL_SLOTS(KS)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .ex_valid_i(ex_valid_i),
        .alu_result_i(alu_result_i), .aN_i(aN_i), .aZ_i(aZ_i), .aC_i(aC_i), .aV_i(aV_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .funct3_i(funct3_i),
        .pc_target_i(pc_target_i), .pc_plus4_i(pc_plus4_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_wdata_i(mem_wdata_i), .wb_sel_i(wb_sel_i),
        .mem_valid_o(mem_valid_o), .alu_result_o(alu_result_o), .pc_plus4_o(pc_plus4_o),
        .mem_wdata_o(mem_wdata_o), .rd_o(rd_o), .wb_sel_o(wb_sel_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    function automatic bit branch_taken(input logic [2:0] f3, input logic n, z, c, v);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return n != v;
            3'd5:    return n == v;
            3'd6:    return !c;
            3'd7:    return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit live, take, mis;
        if (!rst_n) begin
            {e_valid, e_rw, e_mr, e_mw, e_redir, e_mis} = '0;
            e_alu = 0; e_pc4 = 0; e_wdata = 0; e_rpc = 0; e_rd = 0; e_wb = 0;
            m_squash = 0;
        end else if (stall_i) begin
            e_redir = 1'b0;
            e_mis   = 1'b0;
        end else begin
            live = ex_valid_i && !flush_i && (m_squash == 0);
            take = is_jump_i || (is_branch_i && branch_taken(funct3_i, aN_i, aZ_i, aC_i, aV_i));
`ifdef EXMEM_MISALIGN_EN
            mis = live && take && (pc_target_i % 4 != 0);
`else
            mis = 1'b0;
`endif
            e_valid = live;
            e_alu = alu_result_i; e_pc4 = pc_plus4_i; e_wdata = mem_wdata_i;
            e_rd = rd_i; e_wb = wb_sel_i;
            e_rw = reg_write_i && live;
            e_mr = mem_read_i && live;
            e_mw = mem_write_i && live;
            e_redir = live && take && !mis;
            e_mis = mis;
            e_rpc = pc_target_i;
            if (live && take && !mis) m_squash = KS;
            else if (ex_valid_i && m_squash > 0) m_squash = m_squash - 1;
        end
    endtask

    task automatic compare_all();
        chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, e_valid});
        chk("alu_result", alu_result_o, e_alu);
        chk("pc_plus4", pc_plus4_o, e_pc4);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("rd", {27'd0, rd_o}, {27'd0, e_rd});
        chk("wb_sel", {30'd0, wb_sel_o}, {30'd0, e_wb});
        chk("reg_write", {31'd0, reg_write_o}, {31'd0, e_rw});
        chk("mem_read", {31'd0, mem_read_o}, {31'd0, e_mr});
        chk("mem_write", {31'd0, mem_write_o}, {31'd0, e_mw});
        chk("redirect", {31'd0, redirect_o}, {31'd0, e_redir});
        chk("redirect_pc", redirect_pc_o, e_rpc);
        chk("misalign", {31'd0, misalign_o}, {31'd0, e_mis});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    // Present one instruction; payload fields are random, control is explicit
    task automatic ins(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                       input logic [3:0] nzcv, input logic [31:0] tgt, input logic rw);
        rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        ex_valid_i = v; is_branch_i = br; is_jump_i = jmp; funct3_i = f3;
        {aN_i, aZ_i, aC_i, aV_i} = nzcv;
        pc_target_i = tgt; reg_write_i = rw;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        alu_result_i = $urandom; pc_plus4_i = $urandom; mem_wdata_i = $urandom;
        rd_i = 5'($urandom); wb_sel_i = 2'($urandom);
    endtask

    task automatic nop();
        ins(1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 32'h0, 1'b1);
    endtask

    // Feed the squashed slots that follow a redirect and expect them to be bubbles
    task automatic drain(input string tag);
        for (int k = 0; k < KS; k++) begin
            nop(); step();
            chk({tag, "_killed_valid"}, {31'd0, mem_valid_o}, 32'd0);
            chk({tag, "_killed_rw"}, {31'd0, reg_write_o}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        step(); step();
        chk("lit_reset_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("lit_reset_rpc", redirect_pc_o, 32'd0);
        chk("lit_reset_redir", {31'd0, redirect_o}, 32'd0);

        // BEQ taken, two squashed, third live
        ins(1'b1, 1'b1, 1'b0, 3'b000, 4'b0100, 32'h0000_0100, 1'b0); step();
        chk("lit_beq_redir", {31'd0, redirect_o}, 32'd1);
        chk("lit_beq_rpc", redirect_pc_o, 32'h0000_0100);
        drain("beq");
        nop(); step();
        chk("lit_beq_third_live", {31'd0, mem_valid_o}, 32'd1);
        chk("lit_beq_third_redir", {31'd0, redirect_o}, 32'd0);

        // Signed/unsigned branch conditions
        ins(1'b1, 1'b1, 1'b0, 3'b100, 4'b1000, 32'h0000_0200, 1'b0); step();
        chk("lit_blt_taken", {31'd0, redirect_o}, 32'd1);
        drain("blt");
        ins(1'b1, 1'b1, 1'b0, 3'b100, 4'b1001, 32'h0000_0204, 1'b0); step();
        chk("lit_blt_not", {31'd0, redirect_o}, 32'd0);
        chk("lit_blt_not_valid", {31'd0, mem_valid_o}, 32'd1);
        ins(1'b1, 1'b1, 1'b0, 3'b111, 4'b0010, 32'h0000_0300, 1'b0); step();
        chk("lit_bgeu_taken", {31'd0, redirect_o}, 32'd1);
        drain("bgeu");
        ins(1'b1, 1'b1, 1'b0, 3'b110, 4'b0010, 32'h0000_0304, 1'b0); step();
        chk("lit_bltu_not", {31'd0, redirect_o}, 32'd0);

        // Plain ALU op, then the same op flushed
        nop(); alu_result_i = 32'hDEAD_BEEF; rd_i = 5'd5; step();
        chk("lit_add_alu", alu_result_o, 32'hDEAD_BEEF);
        chk("lit_add_rd", {27'd0, rd_o}, 32'd5);
        chk("lit_add_rw", {31'd0, reg_write_o}, 32'd1);
        nop(); alu_result_i = 32'hDEAD_BEEF; rd_i = 5'd5; flush_i = 1'b1; step();
        chk("lit_flush_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("lit_flush_rw", {31'd0, reg_write_o}, 32'd0);

        // Taken JAL held across a 3-cycle stall
        ins(1'b1, 1'b0, 1'b1, 3'd0, 4'b0000, 32'h0000_0400, 1'b1); alu_result_i = 32'h1234_5678; step();
        chk("lit_jal_redir", {31'd0, redirect_o}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            nop(); stall_i = 1'b1; flush_i = 1'b1; step();
            chk("lit_stall_redir", {31'd0, redirect_o}, 32'd0);
            chk("lit_stall_hold_alu", alu_result_o, 32'h1234_5678);
            chk("lit_stall_hold_valid", {31'd0, mem_valid_o}, 32'd1);
        end
        drain("stall");
        nop(); step();
        chk("lit_stall_after_live", {31'd0, mem_valid_o}, 32'd1);

        // Reset in the middle of the kill window
        ins(1'b1, 1'b0, 1'b1, 3'd0, 4'b0000, 32'h0000_0500, 1'b1); step();
        nop(); step();
        nop(); rst_n = 1'b0; stall_i = 1'b1; step();
        chk("lit_rst_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("lit_rst_alu", alu_result_o, 32'd0);
        chk("lit_rst_rpc", redirect_pc_o, 32'd0);
        nop(); step();
        chk("lit_rst_next_live", {31'd0, mem_valid_o}, 32'd1);

        // JALR to a misaligned target
        ins(1'b1, 1'b0, 1'b1, 3'd0, 4'b0000, 32'h0000_0102, 1'b1); step();
`ifdef EXMEM_MISALIGN_EN
        chk("lit_mis_flag", {31'd0, misalign_o}, 32'd1);
        chk("lit_mis_redir", {31'd0, redirect_o}, 32'd0);
        nop(); step();
        chk("lit_mis_next_live", {31'd0, mem_valid_o}, 32'd1);
`else
        chk("lit_mis_redir", {31'd0, redirect_o}, 32'd1);
        chk("lit_mis_rpc", redirect_pc_o, 32'h0000_0102);
        chk("lit_mis_flag", {31'd0, misalign_o}, 32'd0);
        drain("jalr");
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 99) >= 2);
            stall_i      = ($urandom_range(0, 99) < 20);
            flush_i      = ($urandom_range(0, 99) < 10);
            ex_valid_i   = ($urandom_range(0, 99) < 80);
            is_branch_i  = ($urandom_range(0, 99) < 30);
            is_jump_i    = ($urandom_range(0, 99) < 10);
            funct3_i     = 3'($urandom);
            {aN_i, aZ_i, aC_i, aV_i} = 4'($urandom);
            pc_target_i  = $urandom;
            pc_plus4_i   = $urandom;
            alu_result_i = $urandom;
            mem_wdata_i  = $urandom;
            rd_i         = 5'($urandom);
            wb_sel_i     = 2'($urandom);
            reg_write_i  = 1'($urandom);
            mem_read_i   = 1'($urandom);
            mem_write_i  = 1'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
